// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal mesh PE-side network interface.
// Packet field layout, processor register map and small packet helpers.
package cardinal_pkg;

  // Packet geometry
  localparam int PKT_W   = 64;
  localparam int VC_POS  = 63;
  localparam int DIR_HI  = 62;
  localparam int DIR_LO  = 61;
  localparam int RSV_HI  = 60;
  localparam int RSV_LO  = 56;
  localparam int HOP_HI  = 55;
  localparam int HOP_LO  = 48;
  localparam int SRC_HI  = 47;
  localparam int SRC_LO  = 32;
  localparam int PAY_HI  = 31;
  localparam int PAY_LO  = 0;

  // Processor-visible register map
  localparam logic [1:0] ADDR_IBUF  = 2'b00;
  localparam logic [1:0] ADDR_ISTAT = 2'b01;
  localparam logic [1:0] ADDR_OBUF  = 2'b10;
  localparam logic [1:0] ADDR_OSTAT = 2'b11;

  // Field view of a packet, MSB first
  typedef struct packed {
    logic        vc;
    logic [1:0]  dir;
    logic [4:0]  rsv;
    logic [7:0]  hops;
    logic [15:0] src;
    logic [31:0] payload;
  } packet_t;

  // Virtual channel carried by a packet
  function automatic logic pkt_vc(input logic [PKT_W-1:0] pkt);
    return pkt[VC_POS];
  endfunction

endpackage

// File: rtl/nic_channel_buf.sv
// Single-entry packet buffer with a full flag.
// load captures new data and sets full; clear empties the slot.
// The data register keeps its last value after a clear so a stale read
// still returns the previous packet.
module nic_channel_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic         full,
  output logic [W-1:0] data
);

  // Occupancy flag and held packet; a load in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (load) begin
        full <= 1'b1;
        data <= load_data;
      end else if (clear) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic: PE-side network interface for the cardinal mesh router.
// Four processor registers (input buffer/status, output buffer/status),
// one single-entry buffer per direction.
// Optional build macro CARDINAL_NIC_PKT_CNT_EN adds 32-bit tx/rx packet
// counters reported in the upper half of the status registers.
//
// Handshake (both directions): a packet moves on a rising edge where the
// sender's valid (net_so / net_si) and the receiver's ready (net_ro / net_ri)
// are both high. Valid never depends on ready in the same cycle, and a
// sender holding valid keeps its data stable until the transfer happens.
// Outbound valid is further gated by the router polarity: a VC1 packet is
// only offered while polarity is 0, a VC0 packet only while polarity is 1.
module cardinal_nic
  import cardinal_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int VC_BIT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  logic              rd_en;
  logic              out_load;
  logic              out_clear;
  logic              out_full;
  logic [DATA_W-1:0] obuf;
  logic              in_load;
  logic              in_clear;
  logic              in_full;
  logic [DATA_W-1:0] ibuf;
  logic [DATA_W-1:0] istat;
  logic [DATA_W-1:0] ostat;

  assign rd_en = nicEn & ~nicWrEn;

  // Processor write to the output buffer is accepted only into an empty slot;
  // a write landing on a full buffer (including the injection cycle) is lost.
  assign out_load  = nicEn & nicWrEn & (addr == ADDR_OBUF) & ~out_full;
  assign out_clear = net_so & net_ro;

  // Injection is offered only in the cycle the packet's VC is exposed.
  assign net_so = out_full & (obuf[VC_BIT] != net_polarity);
  assign net_do = obuf;

  // Ejection: accept whenever the input slot is empty; a read of the input
  // buffer frees it. Capture and free never coincide because ready is low
  // whenever there is something to free.
  assign net_ri   = ~in_full;
  assign in_load  = net_si & net_ri;
  assign in_clear = rd_en & (addr == ADDR_IBUF);

  nic_channel_buf #(.W(DATA_W)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .clear     (out_clear),
    .load_data (d_in),
    .full      (out_full),
    .data      (obuf)
  );

  nic_channel_buf #(.W(DATA_W)) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (in_load),
    .clear     (in_clear),
    .load_data (net_di),
    .full      (in_full),
    .data      (ibuf)
  );

`ifdef CARDINAL_NIC_PKT_CNT_EN
  logic [31:0] tx_cnt;
  logic [31:0] rx_cnt;

  // Completed handshakes per direction; wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (out_clear) tx_cnt <= tx_cnt + 32'd1;
      if (in_load)   rx_cnt <= rx_cnt + 32'd1;
    end
  end

  assign istat = {rx_cnt, {(DATA_W-33){1'b0}}, in_full};
  assign ostat = {tx_cnt, {(DATA_W-33){1'b0}}, out_full};
`else
  assign istat = {{(DATA_W-1){1'b0}}, in_full};
  assign ostat = {{(DATA_W-1){1'b0}}, out_full};
`endif

  // Registered read port; holds its value between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd_en) begin
      case (addr)
        ADDR_IBUF:  d_out <= ibuf;
        ADDR_ISTAT: d_out <= istat;
        ADDR_OBUF:  d_out <= obuf;
        default:    d_out <= ostat;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic with a queue-based reference model.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: each buffer is a queue of at most one packet
  logic [63:0] m_out_q[$];
  logic [63:0] m_in_q[$];
  logic [63:0] m_obuf, m_ibuf, m_dout;
  logic [31:0] m_tx, m_rx;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  // Clock
  always #5 clk = ~clk;

  // VC1 travels on even router cycles, VC0 on odd router cycles
  function automatic logic m_exposed(input logic [63:0] p, input int c);
    return p[63] ? (c % 2 == 0) : (c % 2 == 1);
  endfunction

  function automatic logic m_so();
    return (m_out_q.size() != 0) && m_exposed(m_out_q[0], cyc);
  endfunction

  function automatic logic [63:0] m_stat(input logic [31:0] cnt, input logic full);
    logic [63:0] s;
    s = 64'd0;
    s[0] = full;
`ifdef CARDINAL_NIC_PKT_CNT_EN
    s[63:32] = cnt;
`else
    if (cnt == 32'hFFFF_FFFF) s[0] = full;  // counters absent from the map
`endif
    return s;
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge
  task automatic tick();
    logic take, cap, out_was_full;
    @(posedge clk);
    take = m_so() && net_ro;
    cap  = net_si && (m_in_q.size() == 0);
    out_was_full = (m_out_q.size() != 0);
    if (reset) begin
      m_out_q.delete(); m_in_q.delete();
      m_obuf = 0; m_ibuf = 0; m_dout = 0; m_tx = 0; m_rx = 0;
    end else begin
      if (nicEn && !nicWrEn) begin
        case (addr)
          2'd0: m_dout = m_ibuf;
          2'd1: m_dout = m_stat(m_rx, m_in_q.size() != 0);
          2'd2: m_dout = m_obuf;
          default: m_dout = m_stat(m_tx, out_was_full);
        endcase
        if (addr == 2'd0 && m_in_q.size() != 0) void'(m_in_q.pop_front());
      end
      if (take) begin
        void'(m_out_q.pop_front());
        m_tx = m_tx + 1;
      end
      if (nicEn && nicWrEn && addr == 2'd2 && !out_was_full) begin
        m_out_q.push_back(d_in);
        m_obuf = d_in;
      end
      if (cap) begin
        m_in_q.push_back(net_di);
        m_ibuf = net_di;
        m_rx = m_rx + 1;
      end
    end
    cyc = cyc + 1;
    #1;
    net_polarity = cyc[0];
  endtask

  // Drivers
  task automatic drive_idle();
    nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0; net_si = 0; net_di = 0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1; nicWrEn = 1; addr = a; d_in = d;
    tick();
    drive_idle();
  endtask

  task automatic do_read(input logic [1:0] a);
    nicEn = 1; nicWrEn = 0; addr = a;
    tick();
    drive_idle();
  endtask

  task automatic pulse_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; net_ro = 0; drive_idle();
    tick(); tick();
    reset = 0; #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_ri: got %b expected 1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b expected 0", net_so); end
    checks++; if (net_do !== 64'd0) begin errors++; $display("FAIL reset_do: got %h expected 0", net_do); end
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", d_out); end
    do_read(2'd1);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_istat: got %h expected 0", d_out); end
    do_read(2'd3);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_ostat: got %h expected 0", d_out); end
  endtask

  task automatic test_vc1_inject();
    logic [63:0] pkt;
    int lat;
    pkt = 64'h8000_0000_0000_00AA;
    net_ro = 1;
    do_write(2'd2, pkt);
    lat = -1;
    for (int i = 0; i < 4 && lat < 0; i++) begin
      #1;
      checks++; if (net_so !== m_so()) begin errors++; $display("FAIL vc1_so: got %b expected %b", net_so, m_so()); end
      if (net_so === 1'b1) begin
        checks++; if (net_polarity !== 1'b0) begin errors++; $display("FAIL vc1_polarity: got %b expected 0", net_polarity); end
        checks++; if (net_do !== pkt) begin errors++; $display("FAIL vc1_do: got %h expected %h", net_do, pkt); end
        lat = i;
      end
      tick();
    end
    checks++; if (lat < 0 || lat > 1) begin errors++; $display("FAIL vc1_latency: got %0d expected 0..1", lat); end
    do_read(2'd3);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL vc1_ostat: got %h expected 0", d_out); end
  endtask

  task automatic test_vc0_blocked();
    logic [63:0] pkt;
    int pulses, fired;
    pkt = 64'h0000_0000_0000_0011;
    net_ro = 0;
    do_write(2'd2, pkt);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin nicEn = 1; nicWrEn = 1; addr = 2'd2; d_in = 64'h0000_0000_0000_0022; end
      #1;
      checks++; if (net_so !== m_so()) begin errors++; $display("FAIL vc0_so: got %b expected %b", net_so, m_so()); end
      if (net_so === 1'b1) begin
        pulses++;
        checks++; if (cyc % 2 != 1) begin errors++; $display("FAIL vc0_parity: got cycle %0d expected odd", cyc); end
      end
      checks++; if (net_do !== pkt) begin errors++; $display("FAIL vc0_hold: got %h expected %h", net_do, pkt); end
      tick();
      drive_idle();
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL vc0_pulses: got %0d expected 3", pulses); end
    do_read(2'd2);
    checks++; if (d_out !== pkt) begin errors++; $display("FAIL vc0_drop: got %h expected %h", d_out, pkt); end
    net_ro = 1;
    fired = 0;
    for (int i = 0; i < 3 && fired == 0; i++) begin
      #1;
      checks++; if (net_so !== m_so()) begin errors++; $display("FAIL vc0_release_so: got %b expected %b", net_so, m_so()); end
      if (net_so === 1'b1) fired = 1;
      tick();
    end
    checks++; if (fired != 1) begin errors++; $display("FAIL vc0_release: got %0d expected 1", fired); end
    do_read(2'd3);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL vc0_ostat: got %h expected 0", d_out); end
  endtask

  task automatic test_rx();
    logic [63:0] pkt;
    pkt = 64'h0000_1234_0000_5678;
    net_si = 1; net_di = pkt;
    tick();
    net_di = 64'hDEAD_BEEF_0000_0001;
    #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rx_ri_drop: got %b expected 0", net_ri); end
    tick();
    net_si = 0; #1;
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rx_ri_blocked: got %b expected 0", net_ri); end
    do_read(2'd1);
    checks++; if (d_out[0] !== 1'b1 || d_out !== m_dout) begin errors++; $display("FAIL rx_istat: got %h expected %h", d_out, m_dout); end
    do_read(2'd0);
    checks++; if (d_out !== pkt) begin errors++; $display("FAIL rx_ibuf: got %h expected %h", d_out, pkt); end
    #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL rx_ri_free: got %b expected 1", net_ri); end
  endtask

  task automatic test_reset_mid();
    net_ro = 0;
    do_write(2'd2, 64'h8000_0000_0000_0BEE);
    net_si = 1; net_di = 64'h0000_0000_0000_0CAF;
    tick();
    net_si = 0;
    do_read(2'd2);
    pulse_reset();
    #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL mid_so: got %b expected 0", net_so); end
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL mid_ri: got %b expected 1", net_ri); end
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL mid_dout: got %h expected 0", d_out); end
    do_read(2'd3);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL mid_ostat: got %h expected 0", d_out); end
    do_read(2'd1);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL mid_istat: got %h expected 0", d_out); end
  endtask

`ifdef CARDINAL_NIC_PKT_CNT_EN
  task automatic test_counters();
    int fired;
    pulse_reset();
    net_ro = 1;
    for (int k = 0; k < 3; k++) begin
      do_write(2'd2, {k[0], 31'd0, $urandom});
      fired = 0;
      for (int i = 0; i < 4 && fired == 0; i++) begin
        #1;
        if (net_so === 1'b1) fired = 1;
        tick();
      end
      checks++; if (fired != 1) begin errors++; $display("FAIL cnt_inject_%0d: got %0d expected 1", k, fired); end
    end
    for (int k = 0; k < 2; k++) begin
      net_si = 1; net_di = {$urandom, $urandom};
      tick();
      net_si = 0;
      do_read(2'd0);
    end
    do_read(2'd3);
    checks++; if (d_out[63:32] !== 32'd3) begin errors++; $display("FAIL cnt_tx: got %0d expected 3", d_out[63:32]); end
    do_read(2'd1);
    checks++; if (d_out[63:32] !== 32'd2) begin errors++; $display("FAIL cnt_rx: got %0d expected 2", d_out[63:32]); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      nicEn   = $urandom_range(0, 1);
      nicWrEn = $urandom_range(0, 1);
      addr    = 2'($urandom_range(0, 3));
      d_in    = {$urandom, $urandom};
      net_ro  = ($urandom_range(0, 3) != 0);
      net_si  = $urandom_range(0, 1);
      net_di  = {$urandom, $urandom};
      #1;
      checks++; if (net_so !== m_so()) begin errors++; $display("FAIL rand_so: cycle %0d got %b expected %b", i, net_so, m_so()); end
      checks++; if (net_ri !== (m_in_q.size() == 0)) begin errors++; $display("FAIL rand_ri: cycle %0d got %b expected %b", i, net_ri, m_in_q.size() == 0); end
      checks++; if (net_do !== m_obuf) begin errors++; $display("FAIL rand_do: cycle %0d got %h expected %h", i, net_do, m_obuf); end
      tick();
      checks++; if (d_out !== m_dout) begin errors++; $display("FAIL rand_dout: cycle %0d got %h expected %h", i, d_out, m_dout); end
    end
    reset = 0;
    drive_idle();
  endtask

  initial begin
    reset = 1; net_ro = 0; net_polarity = 0;
    drive_idle();
    m_obuf = 0; m_ibuf = 0; m_dout = 0; m_tx = 0; m_rx = 0;
    test_reset();
    test_vc1_inject();
    test_vc0_blocked();
    test_rx();
    test_reset_mid();
`ifdef CARDINAL_NIC_PKT_CNT_EN
    test_counters();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
